ip_rx: RTL and testbench
========================

Name: ip_rx

Overview:
Receive-side IPv4 parser. Sits between the MAC receive path and the UDP/ICMP receivers, mirroring the existing IP transmitter.
- Input is an Ethernet frame byte stream starting at destination MAC byte 0, with preamble/SFD already stripped.
- Filters on MAC address, EtherType, IP version and destination IP, and verifies the header checksum.
- Delivers source addresses, protocol and payload length, then streams the payload to the upper layer with padding removed.

Parameters:
ACCEPT_BROADCAST, 1, 1 = also accept dest MAC FF:FF:FF:FF:FF:FF.
CHECK_CHECKSUM, 1, 1 = drop frames whose IP header checksum fails.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous reset, active-high.
local_mac_addr  in  48  own MAC address.
local_ip_addr  in  32  own IP address.
mac_rx_data  in  8  frame byte.
mac_rx_valid  in  1  byte strobe. Held high contiguously across a frame; low for at least 1 cycle between frames.
mac_rx_end  in  1  qualifies the last byte of the frame (valid only with mac_rx_valid).
mac_rx_err  in  1  FCS/PHY error flag, sampled with mac_rx_end.
ip_rx_hdr_valid  out  1  1-cycle pulse: header accepted; the fields below are stable from this pulse until the next hdr_valid.
ip_rx_type  out  8  IP protocol field.
ip_rx_src_mac  out  48  source MAC.
ip_rx_src_ip  out  32  source IP.
ip_rx_data_length  out  16  total_length − 20.
ip_rx_data  out  8  payload byte.
ip_rx_valid  out  1  payload byte strobe.
ip_rx_last  out  1  with the final payload byte.
ip_rx_done  out  1  1-cycle pulse: accepted frame finished.
ip_rx_error  out  1  valid with ip_rx_done: truncated frame or mac_rx_err.

Behaviour:
- Reset values: all outputs 0. State returns to IDLE and the checksum accumulator clears.
- Start-of-frame: a byte counts as byte 0 only when mac_rx_valid=1 and it was 0 the previous cycle. A reset in mid-frame therefore ignores the rest of that frame.
- Byte counter: 16 bits, incremented per valid byte, cleared in IDLE.
- States:
  - IDLE → ETH_HDR on start-of-frame.
  - ETH_HDR covers bytes 0–13:
    - Capture the dest MAC and compare it with local_mac_addr (or broadcast if enabled).
    - Capture the source MAC.
    - Bytes 12–13 must equal 0x0800.
    - Any mismatch → DROP. Otherwise → IP_HDR after byte 13.
  - IP_HDR covers bytes 14–33:
    - Byte 14 must be 0x45 (no options).
    - Capture total_length (bytes 16–17). total_length < 20 → DROP.
    - Flags/fragment field (bytes 20–21): MF=1 or fragment offset ≠0 → DROP.
    - Capture protocol (byte 23) and source IP (bytes 26–29).
    - Dest IP (bytes 30–33) must equal local_ip_addr.
    - Checksum is checked at the end of byte 33.
  - On pass: ip_rx_hdr_valid pulses the cycle after byte 33 is sampled, with all header fields updated in that same cycle.
    - → PAYLOAD, or → PAD if data_length = 0.
  - PAYLOAD:
    - Each payload byte appears on ip_rx_data/ip_rx_valid exactly 1 cycle after it is sampled.
    - ip_rx_last accompanies byte index data_length−1. → PAD after that byte.
  - PAD: discard the remaining bytes until mac_rx_end.
  - DROP: discard until mac_rx_end. No hdr_valid, done or data outputs are produced.
  - Return to IDLE after the mac_rx_end byte.
- Checksum:
  - One's-complement sum of the ten 16-bit header words, formed as {even byte, odd byte}, added into a 20-bit accumulator as each odd byte arrives.
  - At byte 33, fold twice: sum[15:0] + sum[19:16].
  - Pass when the folded result = 16'hFFFF.
- Frame end:
  - ip_rx_done pulses 1 cycle after the mac_rx_end byte, for accepted frames only.
  - ip_rx_error=1 if mac_rx_err=1, or if the frame ended inside PAYLOAD before data_length bytes were forwarded.
  - On truncation, ip_rx_last is not asserted; the error flag replaces it.
- Frame ends during ETH_HDR/IP_HDR: silent drop, return to IDLE.
- A valid byte arriving in IDLE without a preceding valid-low cycle is ignored.

Decomposition:
- Shared package ip_pkg:
  - ETH_TYPE_IPV4 = 16'h0800, IP_VER_IHL = 8'h45, header offsets (ETH_HDR_LEN = 14, IP_HDR_END = 33), MIN_IP_LEN = 20.
  - State encoding, and protocol constants PROTO_ICMP = 8'h01, PROTO_UDP = 8'h11.
- Sub-module ip_checksum_acc: byte-pairing one's-complement accumulator with clear, byte_valid, odd-byte select and a folded 16-bit result.
  - Reusable by the transmitter and by the UDP checksum logic.

Test Plan:
- Accept: local_ip = C0A800C7, header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, 95 payload bytes.
  - Expect: hdr_valid with type = 0x11, src_ip = C0A80001, data_length = 95.
  - Expect: 95 valid bytes, each 1 cycle after input; last on the 95th; done=1, error=0.
- Same frame with checksum byte 24 changed to 0xB9 → no hdr_valid, valid or done. The next good frame back-to-back (1 idle cycle) is accepted.
- Dest IP C0A800C8, or dest MAC mismatch with ACCEPT_BROADCAST = 0, or EtherType 0x0806 → dropped silently.
  - Broadcast dest MAC with ACCEPT_BROADCAST = 1 → accepted.
- Padding: total_length = 28 (8 payload bytes) in a 60-byte frame → exactly 8 valid bytes, last on the 8th, done 1 cycle after the frame's end byte.
- Truncation: mac_rx_end on the 40th byte of a frame claiming 95 payload bytes → 6 bytes forwarded, no last, done=1 with error=1.
  - mac_rx_err=1 on an otherwise good frame → done with error=1.
- Assert rst at payload byte 10 → all outputs 0 next cycle; the remaining bytes are ignored until valid goes low; the following frame is parsed normally.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared constants and types for the IPv4 receive path.
package ip_pkg;

  // Ethernet / IPv4 header constants
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
  localparam logic [15:0] IP_HDR_END    = 16'd33;
  localparam logic [15:0] MIN_IP_LEN    = 16'd20;
  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;
  // MF flag plus 13-bit fragment offset; DF and the reserved bit are ignored
  localparam logic [15:0] FRAG_MASK     = 16'h3FFF;

  // Frame byte offsets where a header field is complete
  localparam logic [15:0] OFS_DST_MAC_END  = 16'd5;
  localparam logic [15:0] OFS_SRC_MAC_END  = 16'd11;
  localparam logic [15:0] OFS_ETH_TYPE_END = ETH_HDR_LEN - 16'd1;
  localparam logic [15:0] OFS_VER_IHL      = ETH_HDR_LEN;
  localparam logic [15:0] OFS_TOT_LEN_END  = 16'd17;
  localparam logic [15:0] OFS_FRAG_END     = 16'd21;
  localparam logic [15:0] OFS_PROTO        = 16'd23;
  localparam logic [15:0] OFS_SRC_IP_END   = 16'd29;

  // IP protocol numbers
  localparam logic [7:0] PROTO_ICMP = 8'h01;
  localparam logic [7:0] PROTO_UDP  = 8'h11;

  typedef enum logic [2:0] {
    IDLE,
    ETH_HDR,
    IP_HDR,
    PAYLOAD,
    PAD,
    DROP
  } rx_state_t;

endpackage

// File: rtl/ip_checksum_acc.sv
// Byte-pairing one's-complement accumulator. Words are {even byte, odd byte};
// the folded result already includes the word completed by the current byte.
module ip_checksum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic        odd_byte,
  input  logic [7:0]  data,
  output logic [15:0] sum
);

  logic [7:0]  hi_q;
  logic [19:0] acc_q;
  logic [19:0] acc_nxt;
  logic [16:0] fold1;

  // Add the completed word on every odd byte
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_nxt = acc_q;
    if (byte_valid && odd_byte) acc_nxt = acc_q + {4'h0, hi_q, data};
  end

  // Two end-around-carry folds bring the 20-bit sum back to 16 bits
  assign fold1 = {1'b0, acc_nxt[15:0]} + {13'h0, acc_nxt[19:16]};
  assign sum   = fold1[15:0] + {15'h0, fold1[16]};

  // Accumulator register, cleared between headers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) acc_q <= '0;
    else              acc_q <= acc_nxt;
  end

  // Hold the even (high) byte until its partner arrives
  always_ff @(posedge clk) begin
    if (byte_valid && !odd_byte) hi_q <= data;
  end

endmodule

// File: rtl/ip_rx.sv
// Receive-side IPv4 parser: filters Ethernet/IPv4 headers, reports the header
// fields and forwards the payload with the Ethernet padding removed.
module ip_rx
  import ip_pkg::*;
#(
  parameter bit ACCEPT_BROADCAST = 1'b1,
  parameter bit CHECK_CHECKSUM   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_end,
  input  logic        mac_rx_err,
  output logic        ip_rx_hdr_valid,
  output logic [7:0]  ip_rx_type,
  output logic [47:0] ip_rx_src_mac,
  output logic [31:0] ip_rx_src_ip,
  output logic [15:0] ip_rx_data_length,
  output logic [7:0]  ip_rx_data,
  output logic        ip_rx_valid,
  output logic        ip_rx_last,
  output logic        ip_rx_done,
  output logic        ip_rx_error
);

  rx_state_t   state;
  logic        prev_valid;
  logic        sof;
  logic        hdr_state;
  logic        hdr_bad;
  logic [15:0] cnt;
  logic [15:0] rem_q;
  logic [47:0] sh;
  logic [15:0] last16;
  logic [31:0] last32;
  logic [47:0] last48;
  logic [15:0] tot_len_q;
  logic [7:0]  proto_q;
  logic [47:0] src_mac_q;
  logic [31:0] src_ip_q;
  logic [15:0] csum;

  assign sof       = mac_rx_valid && !prev_valid;
  assign hdr_state = (state == ETH_HDR) || (state == IP_HDR);

  // The current byte appended to the header history gives each multi-byte field
  assign last48 = {sh[39:0], mac_rx_data};
  assign last32 = last48[31:0];
  assign last16 = last48[15:0];

  ip_checksum_acc u_csum (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != IP_HDR),
    .byte_valid (mac_rx_valid && (state == IP_HDR)),
    .odd_byte   (cnt[0]),
    .data       (mac_rx_data),
    .sum        (csum)
  );

  // Judge each header field on the byte that completes it
  always_comb begin
    hdr_bad = 1'b0;
    case (cnt)
      OFS_DST_MAC_END:  hdr_bad = !((last48 == local_mac_addr) ||
                                    (ACCEPT_BROADCAST && (last48 == MAC_BROADCAST)));
      OFS_ETH_TYPE_END: hdr_bad = (last16 != ETH_TYPE_IPV4);
      OFS_VER_IHL:      hdr_bad = (mac_rx_data != IP_VER_IHL);
      OFS_TOT_LEN_END:  hdr_bad = (last16 < MIN_IP_LEN);
      OFS_FRAG_END:     hdr_bad = ((last16 & FRAG_MASK) != 16'h0);
      IP_HDR_END:       hdr_bad = (last32 != local_ip_addr) ||
                                  (CHECK_CHECKSUM && (csum != 16'hFFFF));
      default:          hdr_bad = 1'b0;
    endcase
  end

  // Header history and field captures; published only once the header passes
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; the FSM never consumes them before they are written.
    if ((state == IDLE && sof) || (hdr_state && mac_rx_valid)) sh <= last48;
    if (hdr_state && mac_rx_valid) begin
      if (cnt == OFS_SRC_MAC_END) src_mac_q <= last48;
      if (cnt == OFS_TOT_LEN_END) tot_len_q <= last16;
      if (cnt == OFS_PROTO)       proto_q   <= mac_rx_data;
      if (cnt == OFS_SRC_IP_END)  src_ip_q  <= last32;
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      rem_q             <= '0;
      // Tracking valid through reset keeps a mid-frame reset from seeing a false start
      prev_valid        <= mac_rx_valid;
      ip_rx_hdr_valid   <= 1'b0;
      ip_rx_type        <= '0;
      ip_rx_src_mac     <= '0;
      ip_rx_src_ip      <= '0;
      ip_rx_data_length <= '0;
      ip_rx_data        <= '0;
      ip_rx_valid       <= 1'b0;
      ip_rx_last        <= 1'b0;
      ip_rx_done        <= 1'b0;
      ip_rx_error       <= 1'b0;
    end else begin
      prev_valid      <= mac_rx_valid;
      ip_rx_hdr_valid <= 1'b0;
      ip_rx_valid     <= 1'b0;
      ip_rx_last      <= 1'b0;
      ip_rx_done      <= 1'b0;
      ip_rx_error     <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sof && !mac_rx_end) begin
            cnt   <= 16'd1;
            state <= ETH_HDR;
          end
        end
        ETH_HDR, IP_HDR: if (mac_rx_valid) begin
          cnt <= cnt + 16'd1;
          if (mac_rx_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (hdr_bad) begin
            state <= DROP;
          end else if (cnt == OFS_ETH_TYPE_END) begin
            state <= IP_HDR;
          end else if (cnt == IP_HDR_END) begin
            ip_rx_hdr_valid   <= 1'b1;
            ip_rx_type        <= proto_q;
            ip_rx_src_mac     <= src_mac_q;
            ip_rx_src_ip      <= src_ip_q;
            ip_rx_data_length <= tot_len_q - MIN_IP_LEN;
            rem_q             <= tot_len_q - MIN_IP_LEN;
            state             <= (tot_len_q == MIN_IP_LEN) ? PAD : PAYLOAD;
          end
        end
        PAYLOAD: if (mac_rx_valid) begin
          cnt         <= cnt + 16'd1;
          rem_q       <= rem_q - 16'd1;
          ip_rx_valid <= 1'b1;
          ip_rx_data  <= mac_rx_data;
          if (mac_rx_end) begin
            // Ending before the last payload byte flags an error instead of last
            state       <= IDLE;
            cnt         <= '0;
            ip_rx_done  <= 1'b1;
            ip_rx_last  <= (rem_q == 16'd1);
            ip_rx_error <= mac_rx_err || (rem_q != 16'd1);
          end else if (rem_q == 16'd1) begin
            ip_rx_last <= 1'b1;
            state      <= PAD;
          end
        end
        PAD: if (mac_rx_valid) begin
          cnt <= cnt + 16'd1;
          if (mac_rx_end) begin
            state       <= IDLE;
            cnt         <= '0;
            ip_rx_done  <= 1'b1;
            ip_rx_error <= mac_rx_err;
          end
        end
        DROP: if (mac_rx_valid) begin
          cnt <= cnt + 16'd1;
          if (mac_rx_end) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: table of frame scenarios plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_ip_rx;

  localparam logic [47:0] LMAC    = 48'h0200_0000_0001;
  localparam logic [47:0] OMAC    = 48'h0200_0000_0002;
  localparam logic [47:0] BMAC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_MAC = 48'h0211_2233_4455;
  localparam logic [31:0] LIP     = 32'hC0A8_00C7;
  localparam logic [31:0] SRC_IP  = 32'hC0A8_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mac_rx_data = '0;
  logic        mac_rx_valid = 1'b0;
  logic        mac_rx_end = 1'b0;
  logic        mac_rx_err = 1'b0;

  logic        ip_rx_hdr_valid, ip_rx_valid, ip_rx_last, ip_rx_done, ip_rx_error;
  logic [7:0]  ip_rx_type, ip_rx_data;
  logic [47:0] ip_rx_src_mac;
  logic [31:0] ip_rx_src_ip;
  logic [15:0] ip_rx_data_length;

  logic        nb_hdr_valid, nb_valid, nb_last, nb_done, nb_error;
  logic [7:0]  nb_type, nb_data;
  logic [47:0] nb_src_mac;
  logic [31:0] nb_src_ip;
  logic [15:0] nb_len;

  ip_rx dut (
    .clk (clk), .rst (rst),
    .local_mac_addr (LMAC), .local_ip_addr (LIP),
    .mac_rx_data (mac_rx_data), .mac_rx_valid (mac_rx_valid),
    .mac_rx_end (mac_rx_end), .mac_rx_err (mac_rx_err),
    .ip_rx_hdr_valid (ip_rx_hdr_valid), .ip_rx_type (ip_rx_type),
    .ip_rx_src_mac (ip_rx_src_mac), .ip_rx_src_ip (ip_rx_src_ip),
    .ip_rx_data_length (ip_rx_data_length), .ip_rx_data (ip_rx_data),
    .ip_rx_valid (ip_rx_valid), .ip_rx_last (ip_rx_last),
    .ip_rx_done (ip_rx_done), .ip_rx_error (ip_rx_error)
  );

  // Second instance with broadcast acceptance disabled
  ip_rx #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
    .clk (clk), .rst (rst),
    .local_mac_addr (LMAC), .local_ip_addr (LIP),
    .mac_rx_data (mac_rx_data), .mac_rx_valid (mac_rx_valid),
    .mac_rx_end (mac_rx_end), .mac_rx_err (mac_rx_err),
    .ip_rx_hdr_valid (nb_hdr_valid), .ip_rx_type (nb_type),
    .ip_rx_src_mac (nb_src_mac), .ip_rx_src_ip (nb_src_ip),
    .ip_rx_data_length (nb_len), .ip_rx_data (nb_data),
    .ip_rx_valid (nb_valid), .ip_rx_last (nb_last),
    .ip_rx_done (nb_done), .ip_rx_error (nb_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic [7:0]  ver;
    logic [15:0] tot_len;
    logic [15:0] frag;
    logic [31:0] dst_ip;
    logic [7:0]  csum_delta;
    int          flen;
    bit          mac_err;
    bit          exp_hdr;
    bit          exp_nb_hdr;
    int          exp_bytes;
    bit          exp_last;
    bit          exp_done;
    bit          exp_error;
  } tv_t;

  tv_t tv[15];

  logic [7:0] frm[$];
  int         drv_cyc[256];

  int         n_checks = 0;
  int         n_fail = 0;

  // Monitor state
  int          n_hdr, n_nb_hdr, n_done, hdr_cyc, done_cyc;
  bit          done_err;
  logic [7:0]  cap_type;
  logic [47:0] cap_src_mac;
  logic [31:0] cap_src_ip;
  logic [15:0] cap_len;
  logic [7:0]  rx_data[$];
  int          rx_cyc[$];
  bit          rx_last[$];

  always @(negedge clk) begin
    if (ip_rx_hdr_valid) begin
      n_hdr++;
      hdr_cyc     = cyc;
      cap_type    = ip_rx_type;
      cap_src_mac = ip_rx_src_mac;
      cap_src_ip  = ip_rx_src_ip;
      cap_len     = ip_rx_data_length;
    end
    if (nb_hdr_valid) n_nb_hdr++;
    if (ip_rx_valid) begin
      rx_data.push_back(ip_rx_data);
      rx_cyc.push_back(cyc);
      rx_last.push_back(ip_rx_last);
    end
    if (ip_rx_done) begin
      n_done++;
      done_cyc = cyc;
      done_err = ip_rx_error;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_hdr = 0; n_nb_hdr = 0; n_done = 0; hdr_cyc = 0; done_cyc = 0; done_err = 1'b0;
    rx_data.delete(); rx_cyc.delete(); rx_last.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " fields"}, {ip_rx_type, ip_rx_src_ip, ip_rx_data_length, ip_rx_data}, 64'h0);
    check({name, " mac/strobes"},
          {11'h0, ip_rx_src_mac, ip_rx_hdr_valid, ip_rx_valid, ip_rx_last, ip_rx_done, ip_rx_error},
          64'h0);
  endtask

  function automatic tv_t mk(input string name, input logic [47:0] dmac, input logic [15:0] et,
                             input logic [7:0] ver, input logic [15:0] tl, input logic [15:0] frag,
                             input logic [31:0] dip, input logic [7:0] dlt, input int flen,
                             input bit err, input bit eh, input bit enb, input int eb,
                             input bit el, input bit ed, input bit ee);
    tv_t t;
    t.name = name; t.dst_mac = dmac; t.eth_type = et; t.ver = ver; t.tot_len = tl;
    t.frag = frag; t.dst_ip = dip; t.csum_delta = dlt; t.flen = flen; t.mac_err = err;
    t.exp_hdr = eh; t.exp_nb_hdr = enb; t.exp_bytes = eb; t.exp_last = el;
    t.exp_done = ed; t.exp_error = ee;
    return t;
  endfunction

  // Build a frame with a correctly computed header checksum, then corrupt byte 24 by csum_delta
  task automatic build_frame(input tv_t t);
    logic [7:0]  h[20];
    logic [31:0] s;
    logic [15:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(t.dst_mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(SRC_MAC[47-8*i -: 8]);
    frm.push_back(t.eth_type[15:8]);
    frm.push_back(t.eth_type[7:0]);
    h[0] = t.ver;  h[1] = 8'h00; h[2] = t.tot_len[15:8]; h[3] = t.tot_len[7:0];
    h[4] = 8'h00;  h[5] = 8'h00; h[6] = t.frag[15:8];    h[7] = t.frag[7:0];
    h[8] = 8'h40;  h[9] = 8'h11; h[10] = 8'h00;          h[11] = 8'h00;
    for (int i = 0; i < 4; i++) h[12+i] = SRC_IP[31-8*i -: 8];
    for (int i = 0; i < 4; i++) h[16+i] = t.dst_ip[31-8*i -: 8];
    s = 32'h0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, h[2*i], h[2*i+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    c = ~s[15:0];
    h[10] = c[15:8] + t.csum_delta;
    h[11] = c[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(h[i]);
    while (frm.size() < t.flen) frm.push_back(8'((frm.size() * 7 + 3) & 255));
    while (frm.size() > t.flen) void'(frm.pop_back());
  endtask

  // Drive the frame one byte per cycle; optional reset pulse on byte rst_at
  task automatic send_frame(input bit err, input int rst_at);
    for (int k = 0; k < frm.size(); k++) begin
      @(negedge clk);
      if (k == rst_at + 1) begin
        rst = 1'b0;
        check_outputs_zero("reset_mid_frame");
        clear_mon();
      end
      mac_rx_data  = frm[k];
      mac_rx_valid = 1'b1;
      mac_rx_end   = (k == frm.size() - 1);
      mac_rx_err   = err && (k == frm.size() - 1);
      drv_cyc[k]   = cyc;
      if (k == rst_at) rst = 1'b1;
    end
    @(negedge clk);
    mac_rx_valid = 1'b0;
    mac_rx_end   = 1'b0;
    mac_rx_err   = 1'b0;
    mac_rx_data  = 8'h00;
  endtask

  task automatic compare(input tv_t t);
    string n;
    bit    el;
    n = t.name;
    check({n, " hdr_valid count"}, n_hdr, t.exp_hdr);
    check({n, " no-broadcast hdr_valid count"}, n_nb_hdr, t.exp_nb_hdr);
    if (t.exp_hdr) begin
      check({n, " type"}, cap_type, 8'h11);
      check({n, " src_ip"}, cap_src_ip, SRC_IP);
      check({n, " src_mac"}, cap_src_mac, SRC_MAC);
      check({n, " data_length"}, cap_len, t.tot_len - 16'd20);
      check({n, " hdr_valid delay"}, hdr_cyc - drv_cyc[33], 1);
    end
    check({n, " payload byte count"}, rx_data.size(), t.exp_bytes);
    for (int j = 0; j < rx_data.size() && j < t.exp_bytes; j++) begin
      el = t.exp_last && (j == t.exp_bytes - 1);
      check($sformatf("%s payload[%0d] {last,delay,data}", n, j),
            {rx_last[j], 16'(rx_cyc[j] - drv_cyc[34+j]), rx_data[j]},
            {el, 16'd1, frm[34+j]});
    end
    check({n, " done count"}, n_done, t.exp_done);
    if (t.exp_done) begin
      check({n, " error"}, done_err, t.exp_error);
      check({n, " done delay"}, done_cyc - drv_cyc[t.flen-1], 1);
    end
  endtask

  task automatic run_entry(input tv_t t);
    clear_mon();
    build_frame(t);
    send_frame(t.mac_err, -10);
    repeat (4) @(negedge clk);
    compare(t);
  endtask

  initial begin
    tv_t r;
    //          name          dst_mac etype     ver    tot_len  frag      dst_ip        dlt   flen err  hdr nb bytes last done error
    tv[0]  = mk("accept",     LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 129, 0,   1,  1, 95,   1,   1,   0);
    tv[1]  = mk("bad_csum",   LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h1, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[2]  = mk("bad_dst_ip", LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, 32'hC0A800C8, 8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[3]  = mk("bad_mac",    OMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[4]  = mk("arp_type",   LMAC, 16'h0806, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[5]  = mk("broadcast",  BMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 129, 0,   1,  0, 95,   1,   1,   0);
    tv[6]  = mk("padding",    LMAC, 16'h0800, 8'h45, 16'd28,   16'h0000, LIP,          8'h0, 60,  0,   1,  1, 8,    1,   1,   0);
    tv[7]  = mk("truncated",  LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 40,  0,   1,  1, 6,    0,   1,   1);
    tv[8]  = mk("mac_err",    LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 129, 1,   1,  1, 95,   1,   1,   1);
    tv[9]  = mk("bad_ver",    LMAC, 16'h0800, 8'h46, 16'h0073, 16'h4000, LIP,          8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[10] = mk("mf_set",     LMAC, 16'h0800, 8'h45, 16'h0073, 16'h2000, LIP,          8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[11] = mk("frag_ofs",   LMAC, 16'h0800, 8'h45, 16'h0073, 16'h0001, LIP,          8'h0, 129, 0,   0,  0, 0,    0,   0,   0);
    tv[12] = mk("len_19",     LMAC, 16'h0800, 8'h45, 16'd19,   16'h0000, LIP,          8'h0, 60,  0,   0,  0, 0,    0,   0,   0);
    tv[13] = mk("len_20",     LMAC, 16'h0800, 8'h45, 16'd20,   16'h0000, LIP,          8'h0, 60,  0,   1,  1, 0,    0,   1,   0);
    tv[14] = mk("short_eth",  LMAC, 16'h0800, 8'h45, 16'h0073, 16'h4000, LIP,          8'h0, 10,  0,   0,  0, 0,    0,   0,   0);

    clear_mon();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) run_entry(tv[i]);

    // Bad checksum frame followed by a good one after a single idle cycle
    clear_mon();
    build_frame(tv[1]);
    send_frame(1'b0, -10);
    build_frame(tv[0]);
    send_frame(1'b0, -10);
    repeat (4) @(negedge clk);
    r = tv[0];
    r.name = "back_to_back";
    compare(r);

    // Reset on payload byte 10: the rest of the frame must be ignored
    clear_mon();
    build_frame(tv[0]);
    send_frame(1'b0, 34 + 10);
    repeat (4) @(negedge clk);
    r = tv[0];
    r.name = "after_reset_tail";
    r.exp_hdr = 1'b0; r.exp_nb_hdr = 1'b0; r.exp_bytes = 0; r.exp_last = 1'b0;
    r.exp_done = 1'b0; r.exp_error = 1'b0;
    compare(r);
    r = tv[0];
    r.name = "after_reset_frame";
    run_entry(r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
